// File: rtl/spi_clkgen_pkg.sv
// spi_clkgen_pkg: shared defaults and FSM state type for the SPI clock generator.
//   DIV_WIDTH_DEF : default divider width (SCK half-period = div+1 clk cycles)
//   BIT_WIDTH_DEF : default width of the per-transfer SCK-cycle count
//   state_e       : IDLE / RUN / HOLD
package spi_clkgen_pkg;

    localparam int unsigned DIV_WIDTH_DEF = 16;
    localparam int unsigned BIT_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/spi_clkgen_clkdiv.sv
// spi_clkdiv: up-counter with synchronous clear and a terminal-count strobe.
// Used both for the SCK half-period and for the post-transfer HOLD window.
//   clk_i   : system clock
//   rst_n_i : asynchronous active-low reset
//   clr_i   : force the count to zero
//   en_i    : count enable
//   div_i   : terminal value
//   tc_o    : high while enabled and count == div_i (count wraps to 0)
module spi_clkdiv
    import spi_clkgen_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tc_o
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    assign tc_o = en_i && !clr_i && (cnt_q == div_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_clkgen.sv
// spi_clkgen: SCK generator and bit-timing strobes for spi_core.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   cpol_i, cpha_i : SPI mode, latched at start
//   div_i          : SCK half-period minus one, latched at start
//   nbit_i         : SCK cycles per transfer, latched at start (0 = immediate done)
//   start_i        : start request, honoured only when idle
//   abort_i        : terminate the current transfer without done_o
//   busy_o         : transfer in progress
//   sck_o          : serial clock
//   sample_o       : capture strobe, shift_o : drive-next-bit strobe
//   last_o         : coincides with the final sample_o
//   done_o         : normal completion pulse
module spi_clkgen
    import spi_clkgen_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF,
    parameter int unsigned BIT_WIDTH = BIT_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cpol_i,
    input  logic                 cpha_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [BIT_WIDTH-1:0] nbit_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 sck_o,
    output logic                 sample_o,
    output logic                 shift_o,
    output logic                 last_o,
    output logic                 done_o
);

    localparam logic [BIT_WIDTH:0] ECNT_ONE = {{BIT_WIDTH{1'b0}}, 1'b1};

    state_e               state_q;
    logic                 cpol_q, cpha_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [BIT_WIDTH-1:0] nbit_q;
    // One bit wider than nbit so 2*nbit edges never wrap.
    logic [BIT_WIDTH:0]   ecnt_q;
    logic                 sck_q, busy_q, sample_q, shift_q, last_q, done_q;

    logic                 tc;
    logic [BIT_WIDTH:0]   ecnt_nxt, nedge;
    logic                 lead, fin, last_smp, start_ok;

    spi_clkdiv #(.DIV_WIDTH(DIV_WIDTH)) u_div (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (state_q == ST_IDLE),
        .en_i    (state_q != ST_IDLE),
        .div_i   (div_q),
        .tc_o    (tc)
    );

    assign ecnt_nxt = ecnt_q + ECNT_ONE;
    assign nedge    = {nbit_q, 1'b0};
    assign lead     = ~ecnt_q[0];
    assign fin      = (ecnt_nxt == nedge);
    // cpha=0 samples on leading edges, so the last sample is edge 2n-1.
    assign last_smp = cpha_q ? fin : (ecnt_nxt == (nedge - ECNT_ONE));
    // busy_q stays high through the done_o cycle while state is already IDLE.
    assign start_ok = start_i && !abort_i && !busy_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            div_q    <= '0;
            nbit_q   <= '0;
            ecnt_q   <= '0;
            sck_q    <= 1'b0;
            busy_q   <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sck_q <= cpol_i;
                    if (done_q || abort_i) begin
                        busy_q <= 1'b0;
                    end
                    if (start_ok) begin
                        if (nbit_i != '0) begin
                            cpol_q  <= cpol_i;
                            cpha_q  <= cpha_i;
                            div_q   <= div_i;
                            nbit_q  <= nbit_i;
                            ecnt_q  <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (tc) begin
                        sck_q  <= ~sck_q;
                        ecnt_q <= ecnt_nxt;
                        if (cpha_q) begin
                            shift_q  <= lead;
                            sample_q <= ~lead;
                        end else begin
                            sample_q <= lead;
                            shift_q  <= ~lead && !fin;
                        end
                        last_q <= last_smp;
                        if (fin) begin
                            state_q <= ST_HOLD;
                        end
                    end
                    if (abort_i) begin
                        // An edge decided this cycle still goes out; idle level follows.
                        if (!tc) begin
                            sck_q <= cpol_q;
                        end
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (tc) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    if (abort_i) begin
                        done_q  <= 1'b0;
                        sck_q   <= cpol_q;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign sck_o    = sck_q;
    assign sample_o = sample_q;
    assign shift_o  = shift_q;
    assign last_o   = last_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_spi_clkgen.sv
module tb_spi_clkgen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpol, cpha, start, abort;
    logic [15:0] div;
    logic [7:0]  nbit;
    logic        busy, sck, sample, shift, last, done;
    logic [5:0]  outs;

    always #5 clk = ~clk;

    spi_clkgen #(.DIV_WIDTH(16), .BIT_WIDTH(8)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .cpol_i   (cpol),
        .cpha_i   (cpha),
        .div_i    (div),
        .nbit_i   (nbit),
        .start_i  (start),
        .abort_i  (abort),
        .busy_o   (busy),
        .sck_o    (sck),
        .sample_o (sample),
        .shift_o  (shift),
        .last_o   (last),
        .done_o   (done)
    );

    assign outs = {busy, sck, sample, shift, last, done};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected strobe/done events: cycle number and {busy,sck,sample,shift,last,done}.
    typedef struct {
        int         cyc;
        logic [5:0] v;
    } ev_t;
    ev_t q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: whenever the DUT shows a strobe or done, pop and compare.
    ev_t mon_e;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (sample | shift | last | done)) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", int'(outs), 0);
            end else begin
                mon_e = q.pop_front();
                chk("event_cycle", cyc, mon_e.cyc);
                chk("event_outputs", int'(outs), int'(mon_e.v));
            end
        end
    end

    // Reference model: edge j of a transfer started in cycle T is visible in
    // cycle T + (d+1)*j + 1; odd edges are leading. Returns the done cycle.
    function automatic int build(input int T, input bit cp, input bit ch, input int d, input int n);
        int  ns;
        bit  lead, s, h, l;
        ns = 0;
        if (n == 0) begin
            q.push_back('{T + 1, {1'b0, cp, 4'b0001}});
            return T + 1;
        end
        for (int j = 1; j <= 2 * n; j++) begin
            lead = (j % 2) == 1;
            s = ch ? !lead : lead;
            h = ch ? lead : (!lead && j != 2 * n);
            if (s) ns++;
            l = s && (ns == n);
            if (s || h) q.push_back('{T + (d + 1) * j + 1, {1'b1, cp ^ lead, s, h, l, 1'b0}});
        end
        q.push_back('{T + 1 + (d + 1) * (2 * n + 1), {1'b1, cp, 4'b0001}});
        return T + 1 + (d + 1) * (2 * n + 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    // Must be called 1 time unit after a rising edge.
    task automatic run_xfer(input bit cp, input bit ch, input int d, input int n,
                            input int abort_rel, input bit repulse);
        int T, dc, A;
        T     = cyc;
        cpol  = cp;
        cpha  = ch;
        div   = d[15:0];
        nbit  = n[7:0];
        start = 1'b1;
        dc    = build(T, cp, ch, d, n);
        step();
        start = 1'b0;
        if (repulse) begin
            step();
            step();
            cpol  = ~cp;
            cpha  = ~ch;
            div   = d[15:0] + 16'd3;
            nbit  = n[7:0] + 8'd1;
            start = 1'b1;
            chk("busy_mid_transfer", int'(busy), 1);
            step();
            start = 1'b0;
            cpol  = cp;
            cpha  = ch;
        end
        if (abort_rel > 0) begin
            A = T + abort_rel;
            wait_until(A);
            abort = 1'b1;
            while (q.size() > 0 && (q[q.size()-1].cyc > A + 1 ||
                   (q[q.size()-1].cyc == A + 1 && q[q.size()-1].v[0])))
                void'(q.pop_back());
            if (q.size() > 0 && q[q.size()-1].cyc == A + 1) q[q.size()-1].v[5] = 1'b0;
            step();
            abort = 1'b0;
            chk("abort_busy", int'(busy), 0);
            step();
            chk("abort_sck_idle", int'(sck), int'(cp));
            step();
            chk("abort_queue_drained", q.size(), 0);
        end else begin
            wait_until(dc + 1);
            chk("end_busy", int'(busy), 0);
            chk("end_sck_idle", int'(sck), int'(cp));
            chk("end_queue_drained", q.size(), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, n, r, dcrel;
        bit cp, ch;
        rst_n = 1'b0;
        cpol  = 1'b0;
        cpha  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        div   = '0;
        nbit  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'(outs), 0);
        rst_n = 1'b1;
        step();

        run_xfer(1'b0, 1'b0, 0, 8, 0, 1'b0);     // mode0, fastest SCK
        run_xfer(1'b1, 1'b1, 2, 4, 0, 1'b0);     // mode3
        run_xfer(1'b0, 1'b0, 1, 0, 0, 1'b0);     // nbit=0
        run_xfer(1'b0, 1'b1, 1, 8, 13, 1'b0);    // mode1, abort after 3rd sample
        run_xfer(1'b0, 1'b1, 1, 8, 0, 1'b0);     // restart after abort
        run_xfer(1'b1, 1'b0, 2, 5, 0, 1'b1);     // start re-pulsed mid-transfer
        run_xfer(1'b0, 1'b0, 2, 4, 9, 1'b0);     // abort coinciding with edge 3
        run_xfer(1'b1, 1'b1, 0, 255, 0, 1'b0);   // maximum nbit

        // abort together with start in idle: nothing starts
        cpol  = 1'b0;
        nbit  = 8'd3;
        div   = 16'd0;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_with_start_busy", int'(busy), 0);
        repeat (4) step();
        chk("abort_with_start_quiet", int'(busy), 0);

        for (int i = 0; i < 40; i++) begin
            cp = 1'($urandom_range(0, 1));
            ch = 1'($urandom_range(0, 1));
            d  = $urandom_range(0, 3);
            n  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7);
            r  = $urandom_range(0, 3);
            dcrel = (n == 0) ? 1 : 1 + (d + 1) * (2 * n + 1);
            if (r == 0 && n > 0)
                run_xfer(cp, ch, d, n, $urandom_range(1, dcrel), 1'b0);
            else if (r == 1 && n > 0)
                run_xfer(cp, ch, d, n, 0, 1'b1);
            else
                run_xfer(cp, ch, d, n, 0, 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end

        // asynchronous reset in the middle of a transfer
        void'(build(cyc, 1'b1, 1'b0, 2, 8));
        cpol  = 1'b1;
        cpha  = 1'b0;
        div   = 16'd2;
        nbit  = 8'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'(outs), 0);
        q.delete();
        step();
        step();
        rst_n = 1'b1;
        cpol  = 1'b1;
        step();
        step();
        chk("post_reset_sck_idle", int'(sck), 1);
        chk("post_reset_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
